// File: rtl/r88_pkg.sv
// Shared definitions for the Rocket88 reset/interrupt sequencer.
// Holds the sequencer state encoding, the cause codes reported to the core,
// the default vector addresses, the flags bit marking a BRK push, and a
// helper that picks a vector base address from a cause.
package r88_pkg;

  typedef enum logic [2:0] {
    ST_RST,
    ST_IDLE,
    ST_PUSH_PCH,
    ST_PUSH_PCL,
    ST_PUSH_P,
    ST_VEC_LO,
    ST_VEC_HI,
    ST_LOAD
  } seqStateT;

  typedef enum logic [1:0] {
    CAUSE_RST = 2'd0,
    CAUSE_NMI = 2'd1,
    CAUSE_BRK = 2'd2,
    CAUSE_IRQ = 2'd3
  } causeT;

  localparam logic [15:0] DEF_VEC_NMI = 16'hFFFA;
  localparam logic [15:0] DEF_VEC_RST = 16'hFFFC;
  localparam logic [15:0] DEF_VEC_IRQ = 16'hFFFE;
  localparam int unsigned DEF_BRK_BIT = 4;

  // BRK shares the IRQ vector.
  function automatic logic [15:0] vecBase(input causeT c,
                                          input logic [15:0] vNmi,
                                          input logic [15:0] vRst,
                                          input logic [15:0] vIrq);
    logic [15:0] base;
    case (c)
      CAUSE_RST: base = vRst;
      CAUSE_NMI: base = vNmi;
      default:   base = vIrq;
    endcase
    return base;
  endfunction

endpackage

// File: rtl/r88_sync.sv
// N-flop synchroniser for an asynchronous single-bit input.
// Ports:
//   clk  - sampling clock, rising edge
//   rstN - asynchronous active-low clear of every stage
//   d    - asynchronous input
//   q    - synchronised output (STAGES clocks of latency)
module r88_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rstN,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/r88_intseq.sv
// Rocket88 reset/interrupt sequencer.
// Synchronises NMI and IRQ, arbitrates NMI > BRK > IRQ at an instruction
// boundary, pushes PCH, PCL and flags to the stack, fetches the 16-bit
// vector over a request/ack port, then pulses pcLoad (plus spLoad and
// irqDisable) for one cycle. Reset runs the vector fetch only.
// Ports:
//   sysClock, resetReq (async, active low)
//   nmiReq, irq, irqEn, breakReq, instrBoundary   - request inputs
//   pcIn, flagsIn, spIn                          - core state captured at start
//   busReq, busWrite, busAddr, busWData, busAck, busRData - memory port
//   seqActive                                    - decoder stall
//   pcLoad/pcOut, spLoad/spOut, irqDisable       - one-cycle load pulses
//   cause                                        - 0 rst, 1 NMI, 2 BRK, 3 IRQ
module r88_intseq
  import r88_pkg::*;
#(
  parameter logic [15:0] VEC_NMI     = DEF_VEC_NMI,
  parameter logic [15:0] VEC_RST     = DEF_VEC_RST,
  parameter logic [15:0] VEC_IRQ     = DEF_VEC_IRQ,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned BRK_BIT     = DEF_BRK_BIT
) (
  input  logic        sysClock,
  input  logic        resetReq,
  input  logic        nmiReq,
  input  logic        irq,
  input  logic        irqEn,
  input  logic        breakReq,
  input  logic        instrBoundary,
  input  logic [15:0] pcIn,
  input  logic [7:0]  flagsIn,
  input  logic [15:0] spIn,
  output logic        busReq,
  output logic        busWrite,
  output logic [15:0] busAddr,
  output logic [7:0]  busWData,
  input  logic        busAck,
  input  logic [7:0]  busRData,
  output logic        seqActive,
  output logic        pcLoad,
  output logic [15:0] pcOut,
  output logic        spLoad,
  output logic [15:0] spOut,
  output logic        irqDisable,
  output logic [1:0]  cause
);

  localparam logic [7:0] BRK_MASK = 8'(1 << BRK_BIT);

  seqStateT    state, nextState;
  causeT       causeReg, startCause;
  logic        startSeq;
  logic        reqPhase;
  logic        nmiSync, nmiSyncD, nmiPend;
  logic        irqSync, irqPend;
  logic [15:0] pcCap, spCap;
  logic [7:0]  flagsCap, flagsPush;
  logic [7:0]  vecLo, vecHi;
  logic [15:0] vecAddr;
  logic        accState, accWrite;
  logic [15:0] accAddr;
  logic [7:0]  accWData;
  logic        accDone;

  r88_sync #(.STAGES(SYNC_STAGES)) uNmiSync (
    .clk  (sysClock),
    .rstN (resetReq),
    .d    (nmiReq),
    .q    (nmiSync)
  );

  r88_sync #(.STAGES(SYNC_STAGES)) uIrqSync (
    .clk  (sysClock),
    .rstN (resetReq),
    .d    (irq),
    .q    (irqSync)
  );

  assign irqPend   = irqSync & irqEn;
  assign vecAddr   = vecBase(causeReg, VEC_NMI, VEC_RST, VEC_IRQ);
  assign flagsPush = (causeReg == CAUSE_BRK) ? (flagsCap | BRK_MASK)
                                             : (flagsCap & ~BRK_MASK);
  // Each access spends its first cycle with busReq low (reqPhase = 0), which
  // gives the mandatory idle cycle between consecutive accesses; busAck only
  // counts once the request is actually on the bus.
  assign accDone   = accState & reqPhase & busAck;

  always_comb begin
    nextState  = state;
    startSeq   = 1'b0;
    startCause = CAUSE_RST;
    accState   = 1'b0;
    accWrite   = 1'b0;
    accAddr    = '0;
    accWData   = '0;
    seqActive  = 1'b1;
    pcLoad     = 1'b0;
    pcOut      = '0;
    spLoad     = 1'b0;
    spOut      = '0;
    irqDisable = 1'b0;

    case (state)
      ST_RST: nextState = ST_VEC_LO;

      ST_IDLE: begin
        seqActive = 1'b0;
        if (instrBoundary) begin
          if (nmiPend) begin
            startSeq   = 1'b1;
            startCause = CAUSE_NMI;
          end else if (breakReq) begin
            startSeq   = 1'b1;
            startCause = CAUSE_BRK;
          end else if (irqPend) begin
            startSeq   = 1'b1;
            startCause = CAUSE_IRQ;
          end
          if (startSeq) begin
            nextState = ST_PUSH_PCH;
          end
        end
      end

      ST_PUSH_PCH: begin
        accState = 1'b1;
        accWrite = 1'b1;
        accAddr  = spCap;
        accWData = pcCap[15:8];
        if (accDone) nextState = ST_PUSH_PCL;
      end

      ST_PUSH_PCL: begin
        accState = 1'b1;
        accWrite = 1'b1;
        accAddr  = spCap - 16'd1;
        accWData = pcCap[7:0];
        if (accDone) nextState = ST_PUSH_P;
      end

      ST_PUSH_P: begin
        accState = 1'b1;
        accWrite = 1'b1;
        accAddr  = spCap - 16'd2;
        accWData = flagsPush;
        if (accDone) nextState = ST_VEC_LO;
      end

      ST_VEC_LO: begin
        accState = 1'b1;
        accAddr  = vecAddr;
        if (accDone) nextState = ST_VEC_HI;
      end

      ST_VEC_HI: begin
        accState = 1'b1;
        accAddr  = vecAddr + 16'd1;
        if (accDone) nextState = ST_LOAD;
      end

      ST_LOAD: begin
        pcLoad     = 1'b1;
        pcOut      = {vecHi, vecLo};
        irqDisable = 1'b1;
        if (causeReg != CAUSE_RST) begin
          spLoad = 1'b1;
          spOut  = spCap - 16'd3;
        end
        nextState = ST_IDLE;
      end

      default: nextState = ST_RST;
    endcase

    busReq   = accState & reqPhase;
    busWrite = busReq & accWrite;
    busAddr  = busReq ? accAddr : '0;
    busWData = (busReq & accWrite) ? accWData : '0;
  end

  always_ff @(posedge sysClock or negedge resetReq) begin
    if (!resetReq) begin
      state    <= ST_RST;
      causeReg <= CAUSE_RST;
      reqPhase <= 1'b0;
      nmiSyncD <= 1'b0;
      nmiPend  <= 1'b0;
      pcCap    <= '0;
      spCap    <= '0;
      flagsCap <= '0;
      vecLo    <= '0;
      vecHi    <= '0;
    end else begin
      state    <= nextState;
      reqPhase <= accState & (nextState == state);
      nmiSyncD <= nmiSync;
      // A fresh edge wins over the clear so it is never lost.
      nmiPend  <= (nmiPend & ~(startSeq & (startCause == CAUSE_NMI)))
                | (nmiSync & ~nmiSyncD);
      if (startSeq) begin
        causeReg <= startCause;
        pcCap    <= pcIn;
        spCap    <= spIn;
        flagsCap <= flagsIn;
      end
      if (accDone && state == ST_VEC_LO) vecLo <= busRData;
      if (accDone && state == ST_VEC_HI) vecHi <= busRData;
    end
  end

  assign cause = causeReg;

endmodule
